seg_scan_decoder: RTL and testbench

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

---
 rtl/seg_scan_decoder_pkg.sv | 34 +++
 rtl/seg7_to_hex.sv | 24 ++
 rtl/seg_scan_decoder.sv | 146 ++++++++++++++
 tb/tb_seg_scan_decoder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared seven-segment definitions for the scan decoder and the display driver.
// Patterns are active-low, bit order {g,f,e,d,c,b,a}; the dp line is handled separately.
package seg_scan_decoder_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Entry i holds the pattern that displays hex digit i.
   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
   };

   // Encoder used by the display-driving side.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble, input logic blank);
      hex_to_seg = blank ? SEG_BLANK : SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational seven-segment pattern to hex nibble decoder.
module seg7_to_hex
   import seg_scan_decoder_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] nibble,
   output logic       valid
);

   // Match the pattern against the sixteen digit shapes; a dark digit never matches.
   always_comb begin
      nibble = 4'h0;
      valid  = 1'b0;
      if (pattern != SEG_BLANK) begin
         for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_TABLE[i]) begin
               nibble = 4'(i);
               valid  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed, active-low seven-segment display
// by watching its digit-select and segment lines.
module seg_scan_decoder
   import seg_scan_decoder_pkg::*;
#(
   parameter int STABLE  = 4,
   parameter int TIMEOUT = 1024
)(
   input  logic        clk100mhz,
   input  logic        clr,
   input  logic [3:0]  pos,
   input  logic [7:0]  seg,
   output logic [15:0] value,
   output logic [3:0]  dp,
   output logic        frame_valid,
   output logic        err,
   output logic        stale
);

   localparam int STAB_W = (STABLE > 1) ? $clog2(STABLE) : 1;
   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE - 1);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);

   logic [3:0]        pos_q;
   logic [7:0]        seg_q;
   logic [3:0]        pos_prev;
   logic [7:0]        seg_prev;
   logic [STAB_W-1:0] stab_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic [15:0]       shadow_val;
   logic [3:0]        shadow_dp;
   logic [3:0]        seen;
   logic [3:0]        seen_next;

   logic              pair_changed;
   logic              sample_hit;
   logic              sample_take;
   logic              pos_ok;
   logic [1:0]        sel_idx;
   logic [3:0]        sel_mask;
   logic              commit;
   logic [3:0]        dec_nibble;
   logic              dec_valid;

   seg7_to_hex u_decode (
      .pattern (seg_q[6:0]),
      .nibble  (dec_nibble),
      .valid   (dec_valid)
   );

   // Register the raw display lines, then keep one older copy to detect changes.
   always_ff @(posedge clk100mhz) begin
      if (!clr) begin
         pos_q    <= '1;
         seg_q    <= '1;
         pos_prev <= '1;
         seg_prev <= '1;
      end else begin
         pos_q    <= pos;
         seg_q    <= seg;
         pos_prev <= pos_q;
         seg_prev <= seg_q;
      end
   end

   // Work out which digit is selected and whether this cycle takes a sample.
   always_comb begin
      pos_ok   = 1'b1;
      sel_idx  = 2'd0;
      unique case (pos_q)
         4'b1110: sel_idx = 2'd0;
         4'b1101: sel_idx = 2'd1;
         4'b1011: sel_idx = 2'd2;
         4'b0111: sel_idx = 2'd3;
         default: pos_ok  = 1'b0;
      endcase
      sel_mask     = 4'b0001 << sel_idx;
      pair_changed = (pos_q != pos_prev) || (seg_q != seg_prev);
      // The sample fires on the edge where the counter steps onto its saturation value,
      // so it happens once per stable pair; with STABLE of 1 that is the reload itself.
      sample_hit   = pair_changed ? (STABLE == 1) : (stab_cnt == STAB_MAX - STAB_W'(1));
      sample_take  = sample_hit && pos_ok;
      commit       = (seen == 4'b1111);
      seen_next    = (commit ? 4'b0000 : seen) | (sample_take ? sel_mask : 4'b0000);
   end

   // Stability counter: reload on any change, otherwise count up and stick at the top.
   always_ff @(posedge clk100mhz) begin
      if (!clr) begin
         stab_cnt <= '0;
      end else if (pair_changed) begin
         stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
         stab_cnt <= stab_cnt + STAB_W'(1);
      end
   end

   // Collect decoded digits in the shadow; a commit reads the shadow before this edge's sample lands.
   always_ff @(posedge clk100mhz) begin
      if (!clr) begin
         shadow_val <= '0;
         shadow_dp  <= '0;
         seen       <= '0;
         err        <= 1'b0;
      end else begin
         seen <= seen_next;
         if (sample_take) begin
            shadow_val[{sel_idx, 2'b00} +: 4] <= dec_valid ? dec_nibble : 4'h0;
            shadow_dp[sel_idx]                <= ~seg_q[7];
            if (!dec_valid) begin
               err <= 1'b1;
            end
         end
      end
   end

   // Publish a complete frame and pulse frame_valid for the single commit cycle.
   always_ff @(posedge clk100mhz) begin
      if (!clr) begin
         value       <= '0;
         dp          <= '0;
         frame_valid <= 1'b0;
      end else begin
         frame_valid <= commit;
         if (commit) begin
            value <= shadow_val;
            dp    <= shadow_dp;
         end
      end
   end

   // Cycles since the last commit, held at TIMEOUT once the display has gone quiet.
   always_ff @(posedge clk100mhz) begin
      if (!clr) begin
         to_cnt <= '0;
      end else if (commit) begin
         to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
         to_cnt <= to_cnt + TO_W'(1);
      end
   end

   assign stale = (to_cnt == TO_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios followed by random scanning,
// all compared every cycle against an event-level model of the display protocol.
module tb_seg_scan_decoder;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 64;

   // Common-anode digit codes 0..F, dp off.
   localparam logic [7:0] SEG_CODES [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   logic        clk100mhz = 1'b0;
   logic        clr;
   logic [3:0]  pos;
   logic [7:0]  seg;
   logic [15:0] value;
   logic [3:0]  dp;
   logic        frame_valid;
   logic        err;
   logic        stale;

   int vectors     = 0;
   int miscompares = 0;
   int step_no     = 0;
   int fv_count    = 0;
   int fv_step     = -1;
   int d3_start    = 0;

   // Reference state: what the display has shown, held as digits and pending events.
   logic [15:0] m_value;
   logic [3:0]  m_dp;
   logic        m_fv;
   logic        m_err;
   int          m_to;
   logic [3:0]  m_shadow [4];
   logic [3:0]  m_shadow_dp;
   logic [3:0]  m_seen;
   bit          commit_pend;
   bit          samp_pend;
   logic [11:0] samp_pair;
   logic [11:0] last_pair;
   int          run;

   seg_scan_decoder #(
      .STABLE  (STABLE),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk100mhz   (clk100mhz),
      .clr         (clr),
      .pos         (pos),
      .seg         (seg),
      .value       (value),
      .dp          (dp),
      .frame_valid (frame_valid),
      .err         (err),
      .stale       (stale)
   );

   always #5 clk100mhz = ~clk100mhz;

   function automatic int digit_of(input logic [3:0] p);
      int zeros = 0;
      int idx   = 0;
      for (int i = 0; i < 4; i++) begin
         if (!p[i]) begin
            zeros++;
            idx = i;
         end
      end
      return (zeros == 1) ? idx : -1;
   endfunction

   function automatic int decode(input logic [6:0] s);
      logic [7:0] code;
      for (int i = 0; i < 16; i++) begin
         code = SEG_CODES[i];
         if (s == code[6:0]) return i;
      end
      return -1;
   endfunction

   // Advance the reference by one clock edge given what was driven into that edge.
   task automatic model_edge(input logic [3:0] p, input logic [7:0] s, input logic c);
      int d;
      int n;
      logic [11:0] pair;
      pair = {p, s};
      if (!c) begin
         m_value = '0; m_dp = '0; m_fv = 1'b0; m_err = 1'b0; m_to = 0;
         m_seen = '0; m_shadow_dp = '0;
         for (int i = 0; i < 4; i++) m_shadow[i] = '0;
         commit_pend = 0; samp_pend = 0;
         last_pair = 12'hFFF;
         run = 2;
         return;
      end
      m_fv = 1'b0;
      if (commit_pend) begin
         m_value = {m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]};
         m_dp    = m_shadow_dp;
         m_fv    = 1'b1;
         m_seen  = '0;
         commit_pend = 0;
      end
      if (samp_pend) begin
         d = digit_of(samp_pair[11:8]);
         if (d >= 0) begin
            n = decode(samp_pair[6:0]);
            if (n < 0) begin
               m_err = 1'b1;
               m_shadow[d] = 4'h0;
            end else begin
               m_shadow[d] = 4'(n);
            end
            m_shadow_dp[d] = ~samp_pair[7];
            m_seen[d] = 1'b1;
         end
         samp_pend = 0;
      end
      commit_pend = (m_seen == 4'hF);
      if (m_fv) m_to = 0;
      else if (m_to < TIMEOUT) m_to++;
      if (pair == last_pair) begin
         run++;
      end else begin
         run = 1;
         last_pair = pair;
      end
      if (run == STABLE) begin
         samp_pend = 1;
         samp_pair = pair;
      end
   endtask

   task automatic compare(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      compare("value", value, m_value);
      compare("dp", 16'(dp), 16'(m_dp));
      compare("frame_valid", 16'(frame_valid), 16'(m_fv));
      compare("err", 16'(err), 16'(m_err));
      compare("stale", 16'(stale), 16'(m_to == TIMEOUT));
   endtask

   // Hold one pos/seg pair for n cycles, checking every cycle just after the edge.
   task automatic applyStimulus(input logic [3:0] p, input logic [7:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         pos = p;
         seg = s;
         @(posedge clk100mhz);
         model_edge(p, s, clr);
         #1;
         checkOutput();
         if (frame_valid === 1'b1) begin
            fv_count++;
            fv_step = step_no;
         end
         step_no++;
      end
   endtask

   task automatic do_reset(input int n);
      clr = 1'b0;
      applyStimulus(4'hF, 8'hFF, n);
      clr = 1'b1;
   endtask

   task automatic sweep(input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] s2, input logic [7:0] s3);
      applyStimulus(4'b1110, s0, 8);
      applyStimulus(4'b1101, s1, 8);
      applyStimulus(4'b1011, s2, 8);
      d3_start = step_no;
      applyStimulus(4'b0111, s3, 8);
   endtask

   initial begin
      logic [3:0] rp;
      logic [7:0] rs;
      $display("[TB] seg_scan_decoder bench, STABLE=%0d TIMEOUT=%0d", STABLE, TIMEOUT);
      clr = 1'b0;
      pos = 4'hF;
      seg = 8'hFF;

      do_reset(3);
      compare("rst_value", value, 16'h0000);
      compare("rst_dp", 16'(dp), 16'h0);
      compare("rst_fv", 16'(frame_valid), 16'h0);
      compare("rst_err", 16'(err), 16'h0);
      compare("rst_stale", 16'(stale), 16'h0);

      // Basic sweep 1,2,3,4; the pulse shows STABLE+2 cycles after digit 3 is presented,
      // which is check index STABLE+1 because each check already follows one edge.
      fv_count = 0;
      sweep(8'hF9, 8'hA4, 8'hB0, 8'h99);
      compare("sweep_frames", 16'(fv_count), 16'd1);
      compare("sweep_value", value, 16'h4321);
      compare("sweep_dp", 16'(dp), 16'h0);
      compare("sweep_err", 16'(err), 16'h0);
      compare("sweep_latency", 16'(fv_step - d3_start), 16'(STABLE + 1));

      // Pairs held one cycle short of STABLE are never sampled.
      fv_count = 0;
      for (int r = 0; r < 2; r++) begin
         applyStimulus(4'b1110, 8'h90, STABLE - 1);
         applyStimulus(4'b1101, 8'h80, STABLE - 1);
         applyStimulus(4'b1011, 8'hF8, STABLE - 1);
         applyStimulus(4'b0111, 8'h82, STABLE - 1);
      end
      applyStimulus(4'hF, 8'hFF, 10);
      compare("short_frames", 16'(fv_count), 16'd0);
      compare("short_value", value, 16'h4321);

      // Illegal selects mid-sweep are ignored.
      fv_count = 0;
      applyStimulus(4'b1110, 8'h92, 8);
      applyStimulus(4'b1101, 8'h82, 8);
      applyStimulus(4'b0011, 8'h80, 20);
      applyStimulus(4'b1111, 8'hC0, 20);
      compare("illegal_frames", 16'(fv_count), 16'd0);
      applyStimulus(4'b1011, 8'hF8, 8);
      applyStimulus(4'b0111, 8'h80, 8);
      compare("illegal_done", 16'(fv_count), 16'd1);
      compare("illegal_value", value, 16'h8765);

      // Blank digit flags err and stores zero; dp on digit 0.
      sweep(8'h40, 8'hF9, 8'hFF, 8'hA4);
      compare("blank_value", value, 16'h2010);
      compare("blank_dp", 16'(dp), 16'h1);
      compare("blank_err", 16'(err), 16'h1);
      sweep(8'h88, 8'h83, 8'hC6, 8'hA1);
      compare("sticky_err", 16'(err), 16'h1);
      compare("letters_value", value, 16'hDCBA);

      // Reset mid-frame discards the partial frame.
      fv_count = 0;
      applyStimulus(4'b1110, 8'h86, 8);
      applyStimulus(4'b1101, 8'h8E, 8);
      applyStimulus(4'b1011, 8'hC0, 8);
      do_reset(2);
      applyStimulus(4'b0111, 8'h99, 8);
      applyStimulus(4'hF, 8'hFF, 10);
      compare("partial_frames", 16'(fv_count), 16'd0);
      compare("partial_value", value, 16'h0000);
      compare("partial_err", 16'(err), 16'h0);
      sweep(8'hF9, 8'hA4, 8'hB0, 8'h99);
      compare("resweep_frames", 16'(fv_count), 16'd1);
      compare("resweep_value", value, 16'h4321);

      // Quiet display goes stale; the next commit clears it.
      applyStimulus(4'hF, 8'hFF, TIMEOUT + 5);
      compare("stale_set", 16'(stale), 16'h1);
      fv_count = 0;
      sweep(8'h90, 8'h80, 8'hF8, 8'h82);
      compare("stale_frames", 16'(fv_count), 16'd1);
      compare("stale_clear", 16'(stale), 16'h0);

      // Random scanning with occasional illegal selects, odd patterns and resets.
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 99) < 2) begin
            do_reset(1);
         end
         if ($urandom_range(0, 99) < 85) begin
            rp = 4'hF;
            rp[$urandom_range(0, 3)] = 1'b0;
         end else begin
            rp = 4'($urandom);
         end
         if ($urandom_range(0, 99) < 75) begin
            rs = SEG_CODES[$urandom_range(0, 15)];
            rs[7] = 1'($urandom_range(0, 1));
         end else begin
            rs = 8'($urandom);
         end
         applyStimulus(rp, rs, $urandom_range(STABLE - 2, STABLE + 4));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
